// File: rtl/game_pkg.sv
// Shared game types: barrier table entries, collision bit indices and the
// default arena layout used by the barrier ROM.
package game_pkg;

    localparam int COLL_RIGHT   = 0;
    localparam int COLL_LEFT    = 1;
    localparam int COLL_DOWN    = 2;
    localparam int COLL_UP      = 3;
    localparam int MAX_STEP     = 3;
    localparam int MAX_BARRIERS = 16;

    typedef struct packed {
        logic       valid;
        logic [9:0] bl;
        logic [9:0] br;
        logic [9:0] bt;
        logic [9:0] bb;
    } barrier_t;

    typedef struct packed {
        logic [10:0] l;
        logic [10:0] r;
        logic [10:0] t;
        logic [10:0] b;
    } box_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        PUBLISH
    } scan_state_t;

    localparam barrier_t NO_BARRIER = '0;

    localparam barrier_t B0 = '{1'b1, 10'd100, 10'd140, 10'd80,  10'd200};
    localparam barrier_t B1 = '{1'b1, 10'd500, 10'd540, 10'd80,  10'd200};
    localparam barrier_t B2 = '{1'b1, 10'd100, 10'd140, 10'd280, 10'd400};
    localparam barrier_t B3 = '{1'b1, 10'd500, 10'd540, 10'd280, 10'd400};
    localparam barrier_t B4 = '{1'b1, 10'd260, 10'd380, 10'd220, 10'd260};
    localparam barrier_t B5 = '{1'b1, 10'd300, 10'd340, 10'd40,  10'd120};
    localparam barrier_t B6 = '{1'b1, 10'd300, 10'd340, 10'd360, 10'd440};
    localparam barrier_t B7 = '{1'b1, 10'd20,  10'd60,  10'd220, 10'd260};

    localparam barrier_t [MAX_BARRIERS-1:0] DEFAULT_BARRIERS = {
        {8{NO_BARRIER}}, B7, B6, B5, B4, B3, B2, B1, B0
    };

    function automatic box_t tank_box(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [9:0] s
    );
        box_t bx;
        bx.l = (x < s) ? 11'd0 : {1'b0, x} - {1'b0, s};
        bx.r = {1'b0, x} + {1'b0, s};
        bx.t = (y < s) ? 11'd0 : {1'b0, y} - {1'b0, s};
        bx.b = {1'b0, y} + {1'b0, s};
        return bx;
    endfunction

    // Strict overlap terms keep pure corner contact from blocking.
    function automatic logic [3:0] barrier_hit(
        input box_t        bx,
        input barrier_t    e,
        input logic [10:0] mg
    );
        logic [10:0] bl;
        logic [10:0] br;
        logic [10:0] bt;
        logic [10:0] bb;
        logic        xov;
        logic        yov;
        logic [3:0]  h;
        bl  = {1'b0, e.bl};
        br  = {1'b0, e.br};
        bt  = {1'b0, e.bt};
        bb  = {1'b0, e.bb};
        yov = (bx.b > bt) && (bx.t < bb);
        xov = (bx.r > bl) && (bx.l < br);
        h   = '0;
        h[COLL_RIGHT] = yov && (bx.r <= bl) && ((bx.r + mg) >= bl);
        h[COLL_LEFT]  = yov && (bx.l >= br) && (bx.l <= (br + mg));
        h[COLL_DOWN]  = xov && (bx.b <= bt) && ((bx.b + mg) >= bt);
        h[COLL_UP]    = xov && (bx.t >= bb) && (bx.t <= (bb + mg));
        if (!e.valid) begin
            h = '0;
        end
        return h;
    endfunction

endpackage

// File: rtl/barrier_rom.sv
// Barrier table lookup; also instanced by the barrier renderer.
module barrier_rom
    import game_pkg::*;
#(
    parameter barrier_t [MAX_BARRIERS-1:0] TABLE = DEFAULT_BARRIERS
) (
    input  logic [3:0] idx,
    output barrier_t   entry
);

    assign entry = TABLE[idx];

endmodule

// File: rtl/barrier_collision_unit.sv
// Per-frame sequential barrier scan producing one tank's blocked-side vector.
module barrier_collision_unit
    import game_pkg::*;
#(
    parameter int NUM_BARRIERS = 8,
    parameter int MARGIN       = 3,
    parameter barrier_t [MAX_BARRIERS-1:0] TABLE = DEFAULT_BARRIERS
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [9:0] TankX,
    input  logic [9:0] TankY,
    input  logic [9:0] TankS,
    output logic [3:0] barrier_collision,
    output logic       scan_busy,
    output logic       scan_done,
    output logic       overrun
);

    localparam logic [10:0] MG   = 11'(MARGIN);
    localparam logic [3:0]  LAST = 4'(NUM_BARRIERS - 1);

    logic        sync1_q;
    logic        sync_q;
    logic        prev_q;
    logic        fedge;
    scan_state_t state;
    logic [3:0]  idx;
    logic [3:0]  acc;
    box_t        snap;
    barrier_t    entry;
    logic [3:0]  hit;

    barrier_rom #(
        .TABLE(TABLE)
    ) u_rom (
        .idx  (idx),
        .entry(entry)
    );

    assign fedge = sync_q & ~prev_q;
    assign hit   = barrier_hit(snap, entry, MG);

    // frame_clk comes from another domain; treat it as data.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= frame_clk;
            sync_q  <= sync1_q;
            prev_q  <= sync_q;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state             <= IDLE;
            idx               <= '0;
            acc               <= '0;
            snap              <= '0;
            barrier_collision <= '0;
            scan_busy         <= 1'b0;
            scan_done         <= 1'b0;
            overrun           <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (fedge && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (fedge) begin
                        snap      <= tank_box(TankX, TankY, TankS);
                        acc       <= '0;
                        idx       <= '0;
                        state     <= SCAN;
                        scan_busy <= 1'b1;
                    end
                end
                SCAN: begin
                    acc <= acc | hit;
                    if (idx == LAST) begin
                        state     <= PUBLISH;
                        scan_done <= 1'b1;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                PUBLISH: begin
                    barrier_collision <= acc;
                    state             <= IDLE;
                    scan_busy         <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    scan_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
